// File: rtl/skipjack_iterative_decrypt.sv
// Iterative Skipjack decryptor: one inverse round per clock, 32 rounds per 64-bit block.
// Key bytes are numbered MSB-first: cv0 = key[79:72] ... cv9 = key[7:0].
module skipjack_iterative_decrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [79:0] key,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  localparam logic [7:0] F_TABLE [256] = '{
    8'ha3, 8'hd7, 8'h09, 8'h83, 8'hf8, 8'h48, 8'hf6, 8'hf4, 8'hb3, 8'h21, 8'h15, 8'h78, 8'h99, 8'hb1, 8'haf, 8'hf9,
    8'he7, 8'h2d, 8'h4d, 8'h8a, 8'hce, 8'h4c, 8'hca, 8'h2e, 8'h52, 8'h95, 8'hd9, 8'h1e, 8'h4e, 8'h38, 8'h44, 8'h28,
    8'h0a, 8'hdf, 8'h02, 8'ha0, 8'h17, 8'hf1, 8'h60, 8'h68, 8'h12, 8'hb7, 8'h7a, 8'hc3, 8'he9, 8'hfa, 8'h3d, 8'h53,
    8'h96, 8'h84, 8'h6b, 8'hba, 8'hf2, 8'h63, 8'h9a, 8'h19, 8'h7c, 8'hae, 8'he5, 8'hf5, 8'hf7, 8'h16, 8'h6a, 8'ha2,
    8'h39, 8'hb6, 8'h7b, 8'h0f, 8'hc1, 8'h93, 8'h81, 8'h1b, 8'hee, 8'hb4, 8'h1a, 8'hea, 8'hd0, 8'h91, 8'h2f, 8'hb8,
    8'h55, 8'hb9, 8'hda, 8'h85, 8'h3f, 8'h41, 8'hbf, 8'he0, 8'h5a, 8'h58, 8'h80, 8'h5f, 8'h66, 8'h0b, 8'hd8, 8'h90,
    8'h35, 8'hd5, 8'hc0, 8'ha7, 8'h33, 8'h06, 8'h65, 8'h69, 8'h45, 8'h00, 8'h94, 8'h56, 8'h6d, 8'h98, 8'h9b, 8'h76,
    8'h97, 8'hfc, 8'hb2, 8'hc2, 8'hb0, 8'hfe, 8'hdb, 8'h20, 8'he1, 8'heb, 8'hd6, 8'he4, 8'hdd, 8'h47, 8'h4a, 8'h1d,
    8'h42, 8'hed, 8'h9e, 8'h6e, 8'h49, 8'h3c, 8'hcd, 8'h43, 8'h27, 8'hd2, 8'h07, 8'hd4, 8'hde, 8'hc7, 8'h67, 8'h18,
    8'h89, 8'hcb, 8'h30, 8'h1f, 8'h8d, 8'hc6, 8'h8f, 8'haa, 8'hc8, 8'h74, 8'hdc, 8'hc9, 8'h5d, 8'h5c, 8'h31, 8'ha4,
    8'h70, 8'h88, 8'h61, 8'h2c, 8'h9f, 8'h0d, 8'h2b, 8'h87, 8'h50, 8'h82, 8'h54, 8'h64, 8'h26, 8'h7d, 8'h03, 8'h40,
    8'h34, 8'h4b, 8'h1c, 8'h73, 8'hd1, 8'hc4, 8'hfd, 8'h3b, 8'hcc, 8'hfb, 8'h7f, 8'hab, 8'he6, 8'h3e, 8'h5b, 8'ha5,
    8'had, 8'h04, 8'h23, 8'h9c, 8'h14, 8'h51, 8'h22, 8'hf0, 8'h29, 8'h79, 8'h71, 8'h7e, 8'hff, 8'h8c, 8'h0e, 8'he2,
    8'h0c, 8'hef, 8'hbc, 8'h72, 8'h75, 8'h6f, 8'h37, 8'ha1, 8'hec, 8'hd3, 8'h8e, 8'h62, 8'h8b, 8'h86, 8'h10, 8'he8,
    8'h08, 8'h77, 8'h11, 8'hbe, 8'h92, 8'h4f, 8'h24, 8'hc5, 8'h32, 8'h36, 8'h9d, 8'hcf, 8'hf3, 8'ha6, 8'hbb, 8'hac,
    8'h5e, 8'h6c, 8'ha9, 8'h13, 8'h57, 8'h25, 8'hb5, 8'he3, 8'hbd, 8'ha8, 8'h3a, 8'h01, 8'h05, 8'h59, 8'h2a, 8'h46
  };

  // Key byte cv[idx mod 10], selected by shifting the wanted byte to the top.
  function automatic logic [7:0] cv_byte(input logic [79:0] kv, input logic [6:0] idx);
    logic [3:0]  m;
    logic [79:0] sh;
    m  = 4'(idx % 7'd10);
    sh = kv << {m, 3'b000};
    return sh[79:72];
  endfunction

  function automatic logic [15:0] g_inv(input logic [15:0] w, input logic [79:0] kv,
                                        input logic [4:0] j);
    logic [7:0] g1, g2, g3, g4, g5, g6;
    g5 = w[15:8];
    g6 = w[7:0];
    g4 = F_TABLE[g5 ^ cv_byte(kv, {j, 2'd3})] ^ g6;
    g3 = F_TABLE[g4 ^ cv_byte(kv, {j, 2'd2})] ^ g5;
    g2 = F_TABLE[g3 ^ cv_byte(kv, {j, 2'd1})] ^ g4;
    g1 = F_TABLE[g2 ^ cv_byte(kv, {j, 2'd0})] ^ g3;
    return {g1, g2};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_k;
  logic [15:0] r_w1, r_w2, r_w3, r_w4;
  logic [79:0] r_key;
  logic        r_s_tready, r_m_tvalid;

  logic        w_accept, w_out_fire, w_rule_b;
  logic [4:0]  w_j;
  logic [15:0] w_g, w_kx;
  logic [15:0] w_w1_nxt, w_w2_nxt, w_w3_nxt, w_w4_nxt;

  assign w_accept   = s_axis_tvalid & r_s_tready;
  assign w_out_fire = r_m_tvalid & m_axis_tready;
  assign w_j        = 5'(r_k - 6'd1);
  assign w_g        = g_inv(r_w2, r_key, w_j);
  assign w_kx       = {10'd0, r_k};
  assign w_rule_b   = (r_k >= 6'd25) | ((r_k >= 6'd9) & (r_k <= 6'd16));

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)        w_state_nxt = S_RUN;
      S_RUN:   if (r_k == 6'd1)     w_state_nxt = S_OUT;
      S_OUT:   if (w_out_fire)      w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_w1_nxt = w_g;
    w_w2_nxt = r_w3;
    w_w3_nxt = r_w4;
    w_w4_nxt = r_w1 ^ r_w2 ^ w_kx;
    if (w_rule_b) begin
      w_w2_nxt = w_g ^ r_w3 ^ w_kx;
      w_w4_nxt = r_w1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Handshake flags are registered from the next state, so ready never depends on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_k        <= 6'd0;
      r_w1       <= 16'd0;
      r_w2       <= 16'd0;
      r_w3       <= 16'd0;
      r_w4       <= 16'd0;
      // NOTE: the captured key is an ordinary register, not a memory, so it is reset with the rest.
      r_key      <= 80'd0;
    end else begin
      r_s_tready <= (w_state_nxt == S_IDLE);
      r_m_tvalid <= (w_state_nxt == S_OUT);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_w1  <= s_axis_tdata[63:48];
          r_w2  <= s_axis_tdata[47:32];
          r_w3  <= s_axis_tdata[31:16];
          r_w4  <= s_axis_tdata[15:0];
          r_key <= key;
          r_k   <= 6'd32;
        end
        S_RUN: begin
          r_w1 <= w_w1_nxt;
          r_w2 <= w_w2_nxt;
          r_w3 <= w_w3_nxt;
          r_w4 <= w_w4_nxt;
          r_k  <= r_k - 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = {r_w1, r_w2, r_w3, r_w4};

endmodule
